// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory-side target.
// Optional feature macro used by the top level: MEM_RESP_INIT_EN.
package mem_resp_pkg;

  // Top-level control states: zero-sweep after reset, then normal service.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Deepest read pipeline the design supports.
  localparam int RD_LAT_MAX = 4;

  // Data returned for a read outside the array. It is sliced down to the data width, so it must be at least that wide.
  localparam logic [63:0] OOB_RDATA = 64'h0;

endpackage

// File: rtl/mem_resp_rdpipe.sv
// RD_LAT-deep valid+data delay line for read responses, with async clear.
// Data stages load only when their valid arrives, so the last stage holds
// the previous response while no response is presented.
module mem_resp_rdpipe #(
  parameter int MEM_DW = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [MEM_DW-1:0] i_data,
  output logic              o_vld,
  output logic [MEM_DW-1:0] o_data
);

  logic              r_vld_p  [RD_LAT];
  logic [MEM_DW-1:0] r_data_p [RD_LAT];

  // Shift valid every cycle; move data only alongside a valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld_p[i]  <= 1'b0;
        r_data_p[i] <= '0;
      end
    end else begin
      // stage p0: response captured at the acceptance edge
      r_vld_p[0] <= i_vld;
      if (i_vld) r_data_p[0] <= i_data;
      // stages p1..: pure delay
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        if (r_vld_p[i-1]) r_data_p[i] <= r_data_p[i-1];
      end
    end
  end

  assign o_vld  = r_vld_p[RD_LAT-1];
  assign o_data = r_data_p[RD_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: word array, one request per cycle, no
// back-pressure, writes complete at the edge, reads return in order after
// RD_LAT cycles. Out-of-range and dropped requests raise sticky flags.
// Macro MEM_RESP_INIT_EN: adds the post-reset INIT state that zero-sweeps
// the array (busy high meanwhile). Undefined: starts in RUN, busy = 0.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  output logic              busy,
  output logic              err_oob,
  output logic              err_drop
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MEM_AW:0]  DEPTH_V  = (MEM_AW + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [MEM_DW-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic              r_err_oob;

  logic              w_in_range;
  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic [IDX_W-1:0]  w_idx;
  logic [MEM_DW-1:0] w_rdata;

  // Extra top bit keeps DEPTH == 2^MEM_AW representable in the compare.
  assign w_in_range = ({1'b0, mem_addr} < DEPTH_V);
  assign w_idx      = mem_addr[IDX_W-1:0];
  assign w_acc      = mem_req && (r_state == ST_RUN);
  assign w_wr       = w_acc && mem_write && w_in_range;
  assign w_rd       = w_acc && !mem_write;
  assign w_rdata    = w_in_range ? r_mem[w_idx] : OOB_RDATA[MEM_DW-1:0];

`ifdef MEM_RESP_INIT_EN
  logic [IDX_W-1:0] r_init_ptr;
  logic             r_busy;
  logic             r_err_drop;

  // FSM: sweep init_ptr through the array once, then stay in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_ptr == LAST_IDX) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end else begin
            r_init_ptr <= r_init_ptr + 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Sticky flag for requests that arrive while the sweep is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_err_drop <= 1'b0;
    else if (mem_req && r_state == ST_INIT) r_err_drop <= 1'b1;
  end

  // Array write port: zero sweep during INIT, accepted writes in RUN.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) r_mem[r_init_ptr] <= '0;
    else if (w_wr)          r_mem[w_idx]      <= mem_wdata;
  end

  assign busy     = r_busy;
  assign err_drop = r_err_drop;
`else
  // Without the sweep the controller is in RUN straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= ST_RUN;
  end

  // Array write port: accepted in-range writes only.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= mem_wdata;
  end

  assign busy     = 1'b0;
  assign err_drop = 1'b0;
`endif

  // Sticky flag for any accepted request outside the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_err_oob <= 1'b0;
    else if (w_acc && !w_in_range) r_err_oob <= 1'b1;
  end

  assign err_oob = r_err_oob;

  mem_resp_rdpipe #(
    .MEM_DW (MEM_DW),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_rd),
    .i_data (w_rdata),
    .o_vld  (mem_rdata_vld),
    .o_data (mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (DEPTH=16, RD_LAT=2). Read expectations
// are queued at issue time with their due cycle; a negedge monitor pops and
// compares every response. Works with or without MEM_RESP_INIT_EN.
module tb_mem_responder;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_rdata_vld;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          err_oob;
  logic          err_drop;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  exp_t          sb[$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] hold_exp = '0;

  mem_responder #(
    .MEM_AW (AW),
    .MEM_DW (DW),
    .DEPTH  (DEPTH),
    .RD_LAT (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata_vld (mem_rdata_vld),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .err_oob       (err_oob),
    .err_drop      (err_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard, on time;
  // between responses the data output must hold its last value.
  always @(negedge clk) begin
    if (rst) begin
      hold_exp = '0;
    end else if (mem_rdata_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld: got data %0h at cycle %0d with nothing pending", mem_rdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", mem_rdata, e.data);
        chk("rd_cycle", cyc, e.cyc);
        hold_exp = e.data;
      end
    end else begin
      chk("rdata_hold", mem_rdata, hold_exp);
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic want, input logic [DW-1:0] exp);
    @(posedge clk);
    #1;
    mem_req   = 1'b1;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    if (!wr && want) sb.push_back('{exp, cyc + LAT});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d, 1'b0, '0);
    if (a < DEPTH) mdl[a[3:0]] = d;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    issue(1'b0, a, '0, 1'b1, (a < DEPTH) ? mdl[a[3:0]] : '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      mem_req   = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk("busy_clears", busy, 1'b0);
  endtask

  initial begin
    int n;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_vld", mem_rdata_vld, 1'b0);
    chk("rst_rdata", mem_rdata, '0);
    chk("rst_err_oob", err_oob, 1'b0);
    chk("rst_err_drop", err_drop, 1'b0);
`ifdef MEM_RESP_INIT_EN
    chk("rst_busy", busy, 1'b1);
`else
    chk("rst_busy", busy, 1'b0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef MEM_RESP_INIT_EN
    // INIT length: busy for exactly DEPTH cycles after release
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("init_len", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    rd(8'd5);
    idle(1);
`else
    @(negedge clk);
    chk("busy_noinit", busy, 1'b0);
`endif

    // Write then read-after-write next cycle
    wr(8'd3, 32'hDEADBEEF);
    rd(8'd3);
    idle(1);

    // Preload addr*3 and burst-read 0..7
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i * 3));
    for (int i = 0; i < 8; i++) rd(AW'(i));
    idle(4);

    // Out-of-range read: zero data, flag one cycle later, sticky
    @(negedge clk);
    chk("oob_before", err_oob, 1'b0);
    rd(AW'(DEPTH + 1));
    @(negedge clk);
    chk("oob_same_cycle", err_oob, 1'b0);
    idle(1);
    @(negedge clk);
    chk("oob_set", err_oob, 1'b1);
    // Out-of-range write must not alias onto any word
    wr(AW'(DEPTH), 32'hFFFFFFFF);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(5);
    chk("oob_sticky", err_oob, 1'b1);

    // Reset with reads in flight: no pulses for them, flags cleared
    issue(1'b0, 8'd1, '0, 1'b0, '0);
    issue(1'b0, 8'd2, '0, 1'b0, '0);
    #2 rst = 1'b1;
    mem_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_oob", err_oob, 1'b0);
    chk("mid_rst_vld", mem_rdata_vld, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Request right after reset: dropped in INIT, serviced otherwise
`ifdef MEM_RESP_INIT_EN
    issue(1'b1, 8'd2, 32'h1234, 1'b0, '0);
    issue(1'b0, 8'd2, '0, 1'b0, '0);
    @(negedge clk);
    chk("drop_flag", err_drop, 1'b1);
    chk("drop_busy", busy, 1'b1);
    idle(1);
    wait_run();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    rd(8'd2);
    rd(8'd3);
`else
    wr(8'd2, 32'h1234);
    rd(8'd2);
    @(negedge clk);
    chk("drop_flag", err_drop, 1'b0);
    chk("drop_busy", busy, 1'b0);
    rd(8'd2);
`endif
    idle(6);
    chk("oob_after_rst", err_oob, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the single-port `mem_req` / `mem_write` / `mem_addr` / `mem_wdata` / `mem_rdata_vld` / `mem_rdata` interface driven by the matrix-multiply initiator. It holds an on-chip word array and accepts one request per cycle with no back-pressure. Writes complete at the clock edge; reads return in order after a fixed pipeline latency. It is the reference target for initiator benches and the default local store in small builds.

## Interface
Parameters:
- `MEM_AW`, default 16: address width.
- `MEM_DW`, default 32: data width.
- `DEPTH`, default 4096: number of words; must be ≤ 2^MEM_AW.
- `RD_LAT`, default 2: read latency in cycles; legal range 1..4.

Ports:
- `clk`, input, 1: the single clock; rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `mem_req`, input, 1: request valid this cycle.
- `mem_write`, input, 1: 1 = write, 0 = read; qualified by `mem_req`.
- `mem_addr`, input, MEM_AW: word address.
- `mem_wdata`, input, MEM_DW: write data.
- `mem_rdata_vld`, output, 1: one-cycle pulse per accepted read.
- `mem_rdata`, output, MEM_DW: read data, valid when `mem_rdata_vld` is 1.
- `busy`, output, 1: in INIT; requests are not serviced.
- `err_oob`, output, 1: sticky flag; an out-of-range address was seen.
- `err_drop`, output, 1: sticky flag; a request arrived while `busy` was 1.

## Operation
- Reset values: `mem_rdata_vld` = 0, `mem_rdata` = 0, `err_oob` = 0, `err_drop` = 0, `busy` = 1 (0 when INIT is compiled out). Read pipeline is cleared.
- State machine has two states, INIT and RUN.
  - Reset enters INIT.
  - INIT writes 0 to `init_ptr` each cycle, sweeping addresses 0..DEPTH-1.
  - After the write to DEPTH-1, the FSM moves to RUN.
  - RUN is terminal until the next reset.
- Every cycle in RUN with `mem_req` = 1 is one accepted request. There is no ready signal, and back-to-back requests are legal every cycle.
- Write, in range: `array[mem_addr] <= mem_wdata` at the edge. No response is returned.
- Read, in range: `array[mem_addr]` is sampled at the acceptance edge. It enters the read pipeline and emerges with `mem_rdata_vld` = 1.
- Out of range (`mem_addr` ≥ DEPTH):
  - A write is discarded.
  - A read still produces a `mem_rdata_vld` pulse with `mem_rdata` = 0, so the initiator's response count stays consistent.
  - `err_oob` is set.
- Request with `mem_req` = 1 during INIT: dropped, with no response; `err_drop` is set.
- The error flags clear only on `rst`.
- `mem_rdata` holds its last value while `mem_rdata_vld` = 0.
- Read-after-write to the same address in the following cycle returns the new data.
- Responses are strictly in request order; exactly one pulse per accepted read.
- `rst` asserted mid-operation: in-flight reads are lost (no pulse), the FSM returns to INIT, and array contents are re-cleared.

## Timing
- A read presented in cycle c (sampled at the edge ending c) drives `mem_rdata_vld` = 1 during cycle c+RD_LAT.
- N consecutive reads give N consecutive vld cycles.
- INIT lasts exactly DEPTH cycles after `rst` deasserts. `busy` drops in the cycle the FSM enters RUN, and the first request can be accepted in that cycle.
- `err_*` flags assert in the cycle after the offending request.
- Write and read share the single port. One request per cycle means there is no same-edge conflict.

## Configuration
- `MEM_RESP_INIT_EN` defined: the INIT state and zero sweep are present, as described above.
- Undefined:
  - The FSM starts in RUN.
  - `busy` is tied to 0.
  - `err_drop` never sets.
  - Array contents after reset are undefined (X in simulation).
  - The first request is accepted in the first cycle after `rst` deasserts.

## Structure
- Package `mem_resp_pkg` holds:
  - the state enum (INIT, RUN);
  - `RD_LAT_MAX` = 4;
  - the out-of-range read value constant (all zeros).
- Sub-module `mem_resp_rdpipe` is an RD_LAT-deep valid+data delay line with async clear. It is instantiated once.
- The top level holds the array, FSM, `init_ptr`, range check and error flags.

## Test plan
- Reset with INIT enabled, DEPTH = 16 → `busy` = 1 for 16 cycles. A subsequent read of address 5 returns 0 with vld at c+RD_LAT.
- Write 0xDEADBEEF to address 3, then read address 3 in the next cycle, RD_LAT = 2 → vld exactly 2 cycles after the read, data 0xDEADBEEF.
- 8 back-to-back reads of addresses 0..7 preloaded with addr×3 → 8 consecutive vld cycles with data 0,3,…,21 in order.
- Read of address DEPTH+1 → vld pulse with data 0; `err_oob` = 1 and stays set. A write to DEPTH leaves all words unchanged.
- `mem_req` during INIT → no vld pulse and `err_drop` = 1. Also compile without `MEM_RESP_INIT_EN` → `busy` = 0 from reset and the same request is serviced.
- Assert `rst` with 2 reads in flight → no vld pulses after reset, flags 0, INIT restarts.
